pw_conv_engine: RTL and testbench
=================================

# pw_conv_engine

Parametrised 1x1 (pointwise) convolution engine for the fire-module expand/squeeze path. It streams one input feature map pixel-by-pixel and buffers the CHIN input channels of each pixel locally. It then replays that buffer against DSP_NO-wide weight slices to produce CHOUT output channels in CHOUT/DSP_NO tiles, applying per-channel bias, optional ReLU, a fixed-point rescale and saturation. It replaces per-layer hard-wired expand blocks with one start/done-controlled engine that has input and output handshakes.

## Interface
- WIDTH, 16: data/weight width, signed two's complement
- CHIN, 16: input channels per pixel (>=2)
- CHOUT, 64: output channels; must be a multiple of DSP_NO
- DSP_NO, 64: parallel MAC lanes per tile
- NPIX, 4096: pixels per feature map (WOUT**2)
- FRAC, 14: fractional bits discarded on rescale
- RELU, 1: 1 = clamp negative sums to 0
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a layer when idle
- ifm_data  in  WIDTH  input pixel channel value
- ifm_valid  in  1  ifm_data valid
- ifm_ready  out  1  engine accepts ifm beat this cycle
- w_addr  out  clog2(CHIN*CHOUT/DSP_NO)  weight ROM address, registered
- w_data  in  DSP_NO*WIDTH  weight slice, combinational from w_addr; lane j at [j*WIDTH +: WIDTH]
- bias_tile  out  clog2(CHOUT/DSP_NO) (min 1)  current tile index
- bias_data  in  DSP_NO*2*WIDTH  bias slice for bias_tile, lane j at [j*2*WIDTH +: 2*WIDTH]
- ofm_data  out  DSP_NO*WIDTH  output tile
- ofm_valid  out  1  ofm_data valid
- ofm_ready  in  1  consumer accepts tile
- ofm_pix  out  clog2(NPIX)  pixel index of current output tile
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse after the last tile is accepted

## Operation
- FSM states: IDLE, LOAD, MAC, OUT, DONE.
- IDLE: busy=0. start=1 -> LOAD; clear pixel counter, tile counter and channel counter k.
- LOAD: ifm_ready=1. Each ifm_valid&ifm_ready beat writes pixel buffer[k] and increments k. On the beat with k==CHIN-1 -> MAC; set k=0, tile t=0, w_addr=0 and clear accumulators.
- MAC: one channel per cycle. For each lane j, acc[j] += buf[k] * w_data[j]. w_addr = t*CHIN + k. After k==CHIN-1 -> OUT.
- Accumulator width: 2*WIDTH+clog2(CHIN) bits, signed.
- OUT: sum = acc + sign-extended bias_data[j]. If RELU and sum<0, sum=0. sum is arithmetic-shifted right by FRAC (truncation) and saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. The result is registered into ofm_data; ofm_valid=1.
- OUT exit, when ofm_ready=1: if t<CHOUT/DSP_NO-1 -> MAC with t+1, clear accumulators, reuse the buffer. Else if pix<NPIX-1 -> LOAD with pix+1. Else -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- start while busy is ignored. ifm beats are never accepted outside LOAD.

## Timing
- Reset values: ifm_ready=0, ofm_valid=0, ofm_data=0, w_addr=0, bias_tile=0, ofm_pix=0, busy=0, done=0. FSM state is IDLE.
- Reset mid-layer aborts immediately. No done pulse is issued. A new start is required afterwards.
- busy rises the cycle after start and falls the cycle done is asserted.
- The first ifm beat can be accepted in the cycle after start.
- MAC lasts exactly CHIN cycles per tile.
- ofm_valid rises the cycle after the last MAC cycle. ofm_data, ofm_pix and bias_tile are stable while ofm_valid=1 and ofm_ready=0.
- Zero-stall per-pixel cost: CHIN + T*(CHIN+1) cycles, where T=CHOUT/DSP_NO.
- The handshake completes in the same cycle ofm_valid and ofm_ready are both high. ofm_valid drops the next cycle unless another tile is immediately ready; it is never ready sooner, because each tile needs CHIN MAC cycles.
- ifm_valid gaps stall LOAD only. Buffer contents persist across all tiles of a pixel.

## Test plan
- CHIN=4, CHOUT=8, DSP_NO=4, NPIX=2, FRAC=0, RELU=0. Stimulus: ifm 1,2,3,4 per pixel, all weights 1, bias 0. Required: 4 tiles, each lane =10, ofm_pix 0,0,1,1, then one done pulse.
- Backpressure: hold ofm_ready=0 for 5 cycles on tile 0. Required: ofm_data/ofm_pix stable and no ifm_ready during the hold; results unchanged.
- Saturation/rescale: FRAC=14, WIDTH=16, products that sum to 2^31-1. Required: output 32767. With a sum of -3*2^14, RELU=0 gives -3 and RELU=1 gives 0.
- Bias: acc=5 with bias=-7, RELU=1. Required: output 0. With bias=+7: output 12 (FRAC=0).
- Input stall: ifm_valid toggles 1,0,1,0. Required: ifm_ready only in LOAD, buffer order preserved, outputs identical to the zero-stall run.
- Reset mid-MAC, then start again. Required: outputs at reset values, no done pulse, the next layer produces correct results from pixel 0.

Source files
------------

// File: rtl/pw_conv_engine_if.sv
// Handshake and memory-side bus of the pointwise convolution engine.
// The engine connects through the master modport; the environment through slave.
`timescale 1ns/1ps
interface pw_conv_engine_if #(
    parameter int WIDTH  = 16,
    parameter int CHIN   = 16,
    parameter int CHOUT  = 64,
    parameter int DSP_NO = 64,
    parameter int NPIX   = 4096
);
    localparam int T   = CHOUT / DSP_NO;
    localparam int WAW = (CHIN * T > 1) ? $clog2(CHIN * T) : 1;
    localparam int TW  = (T > 1) ? $clog2(T) : 1;
    localparam int PW  = (NPIX > 1) ? $clog2(NPIX) : 1;

    logic                      start;
    logic [WIDTH-1:0]          ifm_data;
    logic                      ifm_valid;
    logic                      ifm_ready;
    logic [WAW-1:0]            w_addr;
    logic [DSP_NO*WIDTH-1:0]   w_data;
    logic [TW-1:0]             bias_tile;
    logic [DSP_NO*2*WIDTH-1:0] bias_data;
    logic [DSP_NO*WIDTH-1:0]   ofm_data;
    logic                      ofm_valid;
    logic                      ofm_ready;
    logic [PW-1:0]             ofm_pix;
    logic                      busy;
    logic                      done;

    modport master (
        input  start, ifm_data, ifm_valid, w_data, bias_data, ofm_ready,
        output ifm_ready, w_addr, bias_tile, ofm_data, ofm_valid, ofm_pix, busy, done
    );

    modport slave (
        output start, ifm_data, ifm_valid, w_data, bias_data, ofm_ready,
        input  ifm_ready, w_addr, bias_tile, ofm_data, ofm_valid, ofm_pix, busy, done
    );
endinterface

// File: rtl/pw_conv_engine.sv
// 1x1 convolution engine: buffers CHIN channels of a pixel, then replays them
// against DSP_NO-wide weight slices, one output tile per CHIN MAC cycles.
`timescale 1ns/1ps
module pw_conv_engine #(
    parameter int WIDTH  = 16,
    parameter int CHIN   = 16,
    parameter int CHOUT  = 64,
    parameter int DSP_NO = 64,
    parameter int NPIX   = 4096,
    parameter int FRAC   = 14,
    parameter int RELU   = 1
) (
    input logic             clk,
    input logic             rst,
    pw_conv_engine_if.master bus
);
    localparam int T   = CHOUT / DSP_NO;
    localparam int WAW = (CHIN * T > 1) ? $clog2(CHIN * T) : 1;
    localparam int TW  = (T > 1) ? $clog2(T) : 1;
    localparam int PW  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int KW  = $clog2(CHIN);
    localparam int AW  = 2 * WIDTH + $clog2(CHIN);
    localparam int SW  = AW + 1;

    localparam logic [KW-1:0] K_LAST   = KW'(CHIN - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(T - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
    localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< (WIDTH - 1)) - SW'(1);
    localparam logic signed [SW-1:0] SAT_MIN = -(SW'(1) <<< (WIDTH - 1));

    typedef enum logic [2:0] {IDLE, LOAD, MAC, OUT, DONE} state_t;

    state_t                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [TW-1:0]            t_q, t_d;
    logic [PW-1:0]            pix_q, pix_d;
    logic [WAW-1:0]           w_addr_q, w_addr_d;
    logic signed [WIDTH-1:0]  pix_buf_q [CHIN];
    logic signed [WIDTH-1:0]  pix_buf_d [CHIN];
    logic signed [AW-1:0]     acc_q [DSP_NO];
    logic signed [AW-1:0]     acc_d [DSP_NO];
    logic signed [AW-1:0]     acc_nxt [DSP_NO];
    logic signed [2*WIDTH-1:0] prod [DSP_NO];
    logic [DSP_NO*WIDTH-1:0]  ofm_data_q, ofm_data_d;

    // Bias add, optional ReLU, truncating rescale, then saturation to WIDTH.
    function automatic logic [WIDTH-1:0] post_proc(input logic signed [AW-1:0] acc,
                                                   input logic signed [2*WIDTH-1:0] bias);
        logic signed [SW-1:0] sum;
        logic [WIDTH-1:0]     res;
        sum = SW'(acc) + SW'(bias);
        if (RELU != 0 && sum < 0) sum = '0;
        sum = sum >>> FRAC;
        if (sum > SAT_MAX)      res = SAT_MAX[WIDTH-1:0];
        else if (sum < SAT_MIN) res = SAT_MIN[WIDTH-1:0];
        else                    res = sum[WIDTH-1:0];
        return res;
    endfunction

    always_comb begin
        for (int unsigned j = 0; j < DSP_NO; j++) begin
            prod[j]    = pix_buf_q[k_q] * $signed(bus.w_data[j*WIDTH +: WIDTH]);
            acc_nxt[j] = acc_q[j] + AW'(prod[j]);
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        t_d        = t_q;
        pix_d      = pix_q;
        w_addr_d   = w_addr_q;
        pix_buf_d  = pix_buf_q;
        acc_d      = acc_q;
        ofm_data_d = ofm_data_q;
        unique case (state_q)
            IDLE: if (bus.start) begin
                state_d  = LOAD;
                k_d      = '0;
                t_d      = '0;
                pix_d    = '0;
                w_addr_d = '0;
            end
            LOAD: if (bus.ifm_valid) begin
                pix_buf_d[k_q] = bus.ifm_data;
                if (k_q == K_LAST) begin
                    state_d  = MAC;
                    k_d      = '0;
                    t_d      = '0;
                    w_addr_d = '0;
                    acc_d    = '{default: '0};
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            MAC: begin
                acc_d = acc_nxt;
                // Weight address runs linearly as t*CHIN+k across the tiles of a pixel.
                w_addr_d = w_addr_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = OUT;
                    k_d     = '0;
                    if (t_q == T_LAST) w_addr_d = '0;
                    for (int unsigned j = 0; j < DSP_NO; j++)
                        ofm_data_d[j*WIDTH +: WIDTH] =
                            post_proc(acc_nxt[j], $signed(bus.bias_data[j*2*WIDTH +: 2*WIDTH]));
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            OUT: if (bus.ofm_ready) begin
                acc_d = '{default: '0};
                if (t_q != T_LAST) begin
                    state_d = MAC;
                    t_d     = t_q + 1'b1;
                end else if (pix_q != PIX_LAST) begin
                    state_d = LOAD;
                    pix_d   = pix_q + 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            t_q        <= '0;
            pix_q      <= '0;
            w_addr_q   <= '0;
            pix_buf_q  <= '{default: '0};
            acc_q      <= '{default: '0};
            ofm_data_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            t_q        <= t_d;
            pix_q      <= pix_d;
            w_addr_q   <= w_addr_d;
            pix_buf_q  <= pix_buf_d;
            acc_q      <= acc_d;
            ofm_data_q <= ofm_data_d;
        end
    end

    assign bus.ifm_ready = (state_q == LOAD);
    assign bus.ofm_valid = (state_q == OUT);
    assign bus.busy      = (state_q == LOAD) || (state_q == MAC) || (state_q == OUT);
    assign bus.done      = (state_q == DONE);
    assign bus.w_addr    = w_addr_q;
    assign bus.bias_tile = t_q;
    assign bus.ofm_pix   = pix_q;
    assign bus.ofm_data  = ofm_data_q;
endmodule

// File: tb/tb_pw_conv_engine.sv
// Bench for pw_conv_engine: four FRAC/RELU variants run in lockstep on shared
// stimulus, each output tile compared with an arithmetic reference model.
`timescale 1ns/1ps
module tb_pw_conv_engine;
    localparam int WIDTH  = 16;
    localparam int CHIN   = 4;
    localparam int CHOUT  = 8;
    localparam int DSP_NO = 4;
    localparam int NPIX   = 2;
    localparam int T      = CHOUT / DSP_NO;
    localparam int NTILE  = NPIX * T;
    localparam int NCFG   = 4;
    localparam int WAW    = $clog2(CHIN * T);
    localparam int TW     = (T > 1) ? $clog2(T) : 1;
    localparam int PW     = $clog2(NPIX);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             start     = 1'b0;
    logic             ifm_valid = 1'b0;
    logic             ofm_ready = 1'b0;
    logic [WIDTH-1:0] ifm_data  = '0;

    int ifm_mem [NPIX][CHIN];
    int wmem    [CHIN*T][DSP_NO];
    int bmem    [T][DSP_NO];

    logic                    ifm_ready_a [NCFG];
    logic                    ofm_valid_a [NCFG];
    logic                    busy_a      [NCFG];
    logic                    done_a      [NCFG];
    logic [DSP_NO*WIDTH-1:0] ofm_data_a  [NCFG];
    logic [WAW-1:0]          w_addr_a    [NCFG];
    logic [TW-1:0]           bias_tile_a [NCFG];
    logic [PW-1:0]           ofm_pix_a   [NCFG];

    int     checks   = 0;
    int     failures = 0;
    longint cap [NCFG][NTILE][DSP_NO];

    // Config index c: bit1 selects FRAC=14 (else 0), bit0 selects RELU.
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
        pw_conv_engine_if #(.WIDTH(WIDTH), .CHIN(CHIN), .CHOUT(CHOUT),
                            .DSP_NO(DSP_NO), .NPIX(NPIX)) bus ();
        pw_conv_engine #(.WIDTH(WIDTH), .CHIN(CHIN), .CHOUT(CHOUT), .DSP_NO(DSP_NO),
                         .NPIX(NPIX), .FRAC((gi >= 2) ? 14 : 0), .RELU(gi % 2)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.master)
        );
        assign bus.start     = start;
        assign bus.ifm_data  = ifm_data;
        assign bus.ifm_valid = ifm_valid;
        assign bus.ofm_ready = ofm_ready;
        always_comb begin
            for (int j = 0; j < DSP_NO; j++) begin
                bus.w_data[j*WIDTH +: WIDTH]         = WIDTH'(wmem[bus.w_addr][j]);
                bus.bias_data[j*2*WIDTH +: 2*WIDTH]  = bmem[bus.bias_tile][j];
            end
        end
        assign ifm_ready_a[gi] = bus.ifm_ready;
        assign ofm_valid_a[gi] = bus.ofm_valid;
        assign busy_a[gi]      = bus.busy;
        assign done_a[gi]      = bus.done;
        assign ofm_data_a[gi]  = bus.ofm_data;
        assign w_addr_a[gi]    = bus.w_addr;
        assign bias_tile_a[gi] = bus.bias_tile;
        assign ofm_pix_a[gi]   = bus.ofm_pix;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: dot product, bias, ReLU, floor-divide by 2^FRAC, clamp.
    function automatic longint model(int c, int p, int t, int j);
        longint s = 0;
        longint lim = longint'(1) << (WIDTH - 1);
        int frac = (c >= 2) ? 14 : 0;
        for (int k = 0; k < CHIN; k++)
            s += longint'(ifm_mem[p][k]) * longint'(wmem[t*CHIN + k][j]);
        s += longint'(bmem[t][j]);
        if ((c % 2) == 1 && s < 0) s = 0;
        s = s >>> frac;
        if (s > lim - 1) s = lim - 1;
        if (s < -lim) s = -lim;
        return s;
    endfunction

    function automatic int rnd(int mag);
        return int'($urandom_range(2 * mag)) - mag;
    endfunction

    task automatic fill_random(input int dmag, input int wmag, input int bmag);
        for (int p = 0; p < NPIX; p++)
            for (int k = 0; k < CHIN; k++) ifm_mem[p][k] = rnd(dmag);
        for (int a = 0; a < CHIN*T; a++)
            for (int j = 0; j < DSP_NO; j++) wmem[a][j] = rnd(wmag);
        for (int t = 0; t < T; t++)
            for (int j = 0; j < DSP_NO; j++) bmem[t][j] = rnd(bmag);
    endtask

    task automatic clear_mem();
        for (int p = 0; p < NPIX; p++)
            for (int k = 0; k < CHIN; k++) ifm_mem[p][k] = 0;
        for (int a = 0; a < CHIN*T; a++)
            for (int j = 0; j < DSP_NO; j++) wmem[a][j] = 0;
        for (int t = 0; t < T; t++)
            for (int j = 0; j < DSP_NO; j++) bmem[t][j] = 0;
    endtask

    task automatic check_reset(input string tag);
        for (int c = 0; c < NCFG; c++) begin
            chk($sformatf("%s_c%0d_ifm_ready", tag, c), longint'(ifm_ready_a[c]), 0);
            chk($sformatf("%s_c%0d_ofm_valid", tag, c), longint'(ofm_valid_a[c]), 0);
            chk($sformatf("%s_c%0d_ofm_data", tag, c), longint'(ofm_data_a[c]), 0);
            chk($sformatf("%s_c%0d_w_addr", tag, c), longint'(w_addr_a[c]), 0);
            chk($sformatf("%s_c%0d_bias_tile", tag, c), longint'(bias_tile_a[c]), 0);
            chk($sformatf("%s_c%0d_ofm_pix", tag, c), longint'(ofm_pix_a[c]), 0);
            chk($sformatf("%s_c%0d_busy", tag, c), longint'(busy_a[c]), 0);
            chk($sformatf("%s_c%0d_done", tag, c), longint'(done_a[c]), 0);
        end
    endtask

    // One full layer: feed pixels, collect and check every tile, then the done pulse.
    task automatic run_layer(input string tag, input bit stall, input bit bp_rand,
                             input int hold0, input bit timing_chk);
        int beat = 0;
        int tile = 0;
        int hold = 0;
        int done_cyc = -1;
        bit held = 0;
        logic [DSP_NO*WIDTH-1:0] hd [NCFG];
        logic [PW-1:0]           hp [NCFG];
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < NCFG; c++)
            chk($sformatf("%s_c%0d_busy_rise", tag, c), longint'(busy_a[c]), 1);
        for (int cyc = 0; cyc < 500 && done_cyc < 0; cyc++) begin
            start = (cyc == 6);
            if (beat < NPIX*CHIN) begin
                ifm_valid = stall ? (cyc % 2 == 0) : 1'b1;
            end else begin
                ifm_valid = 1'b0;
            end
            if (ifm_valid) ifm_data = WIDTH'(ifm_mem[beat / CHIN][beat % CHIN]);
            else           ifm_data = WIDTH'($urandom);
            if (tile == 0 && hold < hold0) ofm_ready = 1'b0;
            else ofm_ready = bp_rand ? 1'($urandom_range(1)) : 1'b1;

            if (ifm_valid && ifm_ready_a[0]) beat++;
            if (held) begin
                for (int c = 0; c < NCFG; c++) begin
                    chk($sformatf("%s_c%0d_hold_data", tag, c), longint'(ofm_data_a[c]), longint'(hd[c]));
                    chk($sformatf("%s_c%0d_hold_pix", tag, c), longint'(ofm_pix_a[c]), longint'(hp[c]));
                end
            end
            held = 0;
            if (ofm_valid_a[0]) begin
                for (int c = 0; c < NCFG; c++) begin
                    chk($sformatf("%s_c%0d_ofm_valid", tag, c), longint'(ofm_valid_a[c]), 1);
                    chk($sformatf("%s_c%0d_no_ifm_ready", tag, c), longint'(ifm_ready_a[c]), 0);
                end
                if (ofm_ready) begin
                    for (int c = 0; c < NCFG; c++) begin
                        chk($sformatf("%s_c%0d_tile%0d_pix", tag, c, tile),
                            longint'(ofm_pix_a[c]), tile / T);
                        chk($sformatf("%s_c%0d_tile%0d_bias_tile", tag, c, tile),
                            longint'(bias_tile_a[c]), tile % T);
                        for (int j = 0; j < DSP_NO; j++) begin
                            cap[c][tile][j] = longint'($signed(ofm_data_a[c][j*WIDTH +: WIDTH]));
                            chk($sformatf("%s_c%0d_tile%0d_lane%0d", tag, c, tile, j),
                                cap[c][tile][j], model(c, tile / T, tile % T, j));
                        end
                    end
                    tile++;
                end else begin
                    if (tile == 0) hold++;
                    held = 1;
                    for (int c = 0; c < NCFG; c++) begin
                        hd[c] = ofm_data_a[c];
                        hp[c] = ofm_pix_a[c];
                    end
                end
            end
            if (done_a[0]) begin
                done_cyc = cyc;
                for (int c = 0; c < NCFG; c++) begin
                    chk($sformatf("%s_c%0d_done", tag, c), longint'(done_a[c]), 1);
                    chk($sformatf("%s_c%0d_busy_fall", tag, c), longint'(busy_a[c]), 0);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        ifm_valid = 1'b0;
        ofm_ready = 1'b0;
        chk($sformatf("%s_done_seen", tag), longint'(done_cyc >= 0), 1);
        chk($sformatf("%s_tile_count", tag), tile, NTILE);
        if (timing_chk)
            chk($sformatf("%s_layer_cycles", tag), done_cyc, NPIX * (CHIN + T * (CHIN + 1)));
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < NCFG; c++) begin
                chk($sformatf("%s_c%0d_done_single", tag, c), longint'(done_a[c]), 0);
                chk($sformatf("%s_c%0d_idle_busy", tag, c), longint'(busy_a[c]), 0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b1;
        @(negedge clk);

        // ifm 1,2,3,4 per pixel, unit weights, zero bias: every lane is 10.
        for (int p = 0; p < NPIX; p++)
            for (int k = 0; k < CHIN; k++) ifm_mem[p][k] = k + 1;
        for (int a = 0; a < CHIN*T; a++)
            for (int j = 0; j < DSP_NO; j++) wmem[a][j] = 1;
        run_layer("basic", 0, 0, 0, 1);
        for (int tl = 0; tl < NTILE; tl++)
            for (int j = 0; j < DSP_NO; j++)
                chk($sformatf("basic_const_t%0d_l%0d", tl, j), cap[0][tl][j], 10);

        run_layer("backpressure", 0, 0, 5, 0);
        for (int tl = 0; tl < NTILE; tl++)
            for (int j = 0; j < DSP_NO; j++)
                chk($sformatf("bp_const_t%0d_l%0d", tl, j), cap[0][tl][j], 10);

        // Lane 0 of pixel 0 sums to 2^31-1; lane 1 of pixel 1 sums to -3*2^14.
        clear_mem();
        ifm_mem[0] = '{32767, 32767, 32767, 1};
        ifm_mem[1] = '{-3, 0, 0, 0};
        wmem[0][0] = 32767; wmem[1][0] = 32767; wmem[2][0] = 4; wmem[3][0] = 1;
        wmem[0][1] = 16384;
        run_layer("sat", 0, 0, 0, 1);
        chk("sat_max_f14_r0", cap[2][0][0], 32767);
        chk("sat_max_f14_r1", cap[3][0][0], 32767);
        chk("sat_max_f0_r0", cap[0][0][0], 32767);
        chk("rescale_neg_f14_r0", cap[2][T][1], -3);
        chk("rescale_neg_f14_r1", cap[3][T][1], 0);
        chk("sat_min_f0_r0", cap[0][T][1], -32768);

        // acc=5 with bias -7 on lane 0 and +7 on lane 1.
        clear_mem();
        for (int p = 0; p < NPIX; p++) ifm_mem[p][0] = 5;
        for (int j = 0; j < DSP_NO; j++) wmem[0][j] = 1;
        bmem[0][0] = -7;
        bmem[0][1] = 7;
        run_layer("bias", 0, 0, 0, 0);
        chk("bias_neg_relu", cap[1][0][0], 0);
        chk("bias_pos_relu", cap[1][0][1], 12);
        chk("bias_neg_norelu", cap[0][0][0], -2);

        fill_random(200, 200, 5000);
        run_layer("rand_nostall", 0, 0, 0, 1);
        run_layer("rand_stall", 1, 1, 0, 0);
        fill_random(32767, 32767, 1 << 29);
        run_layer("rand_full", 1, 1, 3, 0);

        // Abort mid-MAC with an asynchronous reset, then start a fresh layer.
        fill_random(1000, 1000, 100000);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < CHIN; k++) begin
            ifm_valid = 1'b1;
            ifm_data = WIDTH'(ifm_mem[0][k]);
            @(negedge clk);
        end
        ifm_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset("rst_mid");
        @(negedge clk) rst = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            for (int c = 0; c < NCFG; c++) begin
                chk($sformatf("rst_c%0d_no_done", c), longint'(done_a[c]), 0);
                chk($sformatf("rst_c%0d_stay_idle", c), longint'(busy_a[c]), 0);
            end
        end
        fill_random(300, 300, 20000);
        run_layer("after_reset", 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
